// File: rtl/fifo_rr_arbiter_if.sv
// Bundle of producer, consumer and FIFO-control signals for fifo_rr_arbiter.
// The master side is the arbiter; the slave side is the producers/consumer/FIFO.
interface fifo_rr_arbiter_if #(
  parameter int unsigned p_num_req   = 4,
  parameter int unsigned p_data_bits = 32,
  parameter int unsigned p_depth     = 32
);
  localparam int unsigned IDW = $clog2(p_num_req);
  localparam int unsigned OW  = $clog2(p_depth + 1);

  logic [p_num_req-1:0]             req_val;
  logic [p_num_req-1:0]             req_rdy;
  logic [p_num_req*p_data_bits-1:0] req_data;
  logic                             resp_val;
  logic                             resp_rdy;
  logic [p_data_bits-1:0]           resp_data;
  logic [IDW-1:0]                   resp_id;
  logic                             fifo_push;
  logic                             fifo_pop;
  logic [IDW+p_data_bits-1:0]       fifo_wdata;
  logic [IDW+p_data_bits-1:0]       fifo_rdata;
  logic                             fifo_empty;
  logic                             fifo_full;
  logic [OW-1:0]                    occ;

  modport master (
    input  req_val, req_data, resp_rdy, fifo_rdata, fifo_empty, fifo_full,
    output req_rdy, resp_val, resp_data, resp_id, fifo_push, fifo_pop, fifo_wdata, occ
  );

  modport slave (
    output req_val, req_data, resp_rdy, fifo_rdata, fifo_empty, fifo_full,
    input  req_rdy, resp_val, resp_data, resp_id, fifo_push, fifo_pop, fifo_wdata, occ
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one external FIFO among several producers, with a
// per-requester occupancy quota and an ID-tagged single response stream.
module fifo_rr_arbiter #(
  parameter int unsigned p_num_req   = 4,
  parameter int unsigned p_data_bits = 32,
  parameter int unsigned p_depth     = 32,
  parameter int unsigned p_quota     = 8
) (
  input logic               clk,
  input logic               rst,
  fifo_rr_arbiter_if.master bus
);
  localparam int unsigned IDW = $clog2(p_num_req);
  localparam int unsigned CW  = $clog2(p_quota + 1);
  localparam int unsigned OW  = $clog2(p_depth + 1);
  localparam int unsigned DW  = p_data_bits;

  if (p_quota > p_depth || p_quota < 1) begin : g_bad_quota
    $error("fifo_rr_arbiter: p_quota must lie in 1..p_depth");
  end
  if (p_num_req < 2) begin : g_bad_num_req
    $error("fifo_rr_arbiter: p_num_req must be at least 2");
  end
  if (p_depth == 0 || (p_depth & (p_depth - 1)) != 0) begin : g_bad_depth
    $error("fifo_rr_arbiter: p_depth must be a power of 2");
  end

  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q [p_num_req];
  logic [CW-1:0]        cnt_d [p_num_req];
  logic [OW-1:0]        occ_q, occ_d;
  logic [p_num_req-1:0] elig, grant;
  logic [IDW-1:0]       gidx, cand, pop_id;
  logic                 found, push, pop;

  always_comb begin
    for (int i = 0; i < p_num_req; i++) begin
      elig[i] = bus.req_val[i] & (cnt_q[i] < CW'(p_quota));
    end
  end

  // Scan from ptr upward with wrap; reset and a full FIFO mask every grant.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < p_num_req; k++) begin
      cand = IDW'((32'(ptr_q) + unsigned'(k)) % p_num_req);
      if (!found && elig[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        found       = 1'b1;
      end
    end
    if (!rst || bus.fifo_full) begin
      grant = '0;
    end
  end

  assign push           = |grant;
  assign bus.req_rdy    = grant;
  assign bus.fifo_push  = push;
  assign bus.fifo_wdata = {gidx, bus.req_data[gidx*DW +: DW]};

  assign bus.resp_val               = rst & ~bus.fifo_empty;
  assign {bus.resp_id, bus.resp_data} = bus.fifo_rdata;
  assign pop                        = bus.resp_val & bus.resp_rdy;
  assign bus.fifo_pop               = pop;
  assign pop_id                     = bus.fifo_rdata[IDW+DW-1 -: IDW];
  assign bus.occ                    = occ_q;

  always_comb begin
    for (int i = 0; i < p_num_req; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push && gidx == IDW'(i) && !(pop && pop_id == IDW'(i))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (pop && pop_id == IDW'(i) && !(push && gidx == IDW'(i))) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (gidx == IDW'(p_num_req - 1)) ? '0 : gidx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < p_num_req; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      occ_q <= occ_d;
      for (int i = 0; i < p_num_req; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: two configurations (quota 8 and quota 32), each
// attached to a behavioural 32-entry FIFO, driven by directed vectors.
module tb_fifo_rr_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DB = 32;
  localparam int unsigned DP = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [NR-1:0]    req_val   [2];
  logic [NR*DB-1:0] req_data  [2];
  logic             resp_rdy  [2];
  logic [NR-1:0]    req_rdy   [2];
  logic             resp_val  [2];
  logic [DB-1:0]    resp_data [2];
  logic [1:0]       resp_id   [2];
  logic             fifo_push [2];
  logic             fifo_pop  [2];
  logic [5:0]       occ       [2];
  logic             fempty    [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int unsigned Q = (k == 0) ? 8 : 32;

    fifo_rr_arbiter_if #(.p_num_req(NR), .p_data_bits(DB), .p_depth(DP)) bus ();

    fifo_rr_arbiter #(
      .p_num_req  (NR),
      .p_data_bits(DB),
      .p_depth    (DP),
      .p_quota    (Q)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.req_val   = req_val[k];
    assign bus.req_data  = req_data[k];
    assign bus.resp_rdy  = resp_rdy[k];
    assign req_rdy[k]    = bus.req_rdy;
    assign resp_val[k]   = bus.resp_val;
    assign resp_data[k]  = bus.resp_data;
    assign resp_id[k]    = bus.resp_id;
    assign fifo_push[k]  = bus.fifo_push;
    assign fifo_pop[k]   = bus.fifo_pop;
    assign occ[k]        = bus.occ;

    // Behavioural FIFO with a synchronous clear while rst is low.
    logic [33:0] mem [DP];
    logic [4:0]  wp, rp;
    logic [5:0]  cnt;
    int          idcnt [NR];
    logic        push_ok, pop_ok;

    assign push_ok        = bus.fifo_push && cnt != 6'd32;
    assign pop_ok         = bus.fifo_pop && cnt != 6'd0;
    assign bus.fifo_rdata = mem[rp];
    assign bus.fifo_full  = (cnt == 6'd32);
    assign bus.fifo_empty = (cnt == 6'd0);
    assign fempty[k]      = bus.fifo_empty;

    always @(posedge clk) begin
      if (!rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        for (int i = 0; i < NR; i++) idcnt[i] <= 0;
      end else begin
        if (push_ok) begin
          mem[wp] <= bus.fifo_wdata;
          wp      <= wp + 5'd1;
        end
        if (pop_ok) rp <= rp + 5'd1;
        cnt <= cnt + {5'd0, push_ok} - {5'd0, pop_ok};
        for (int i = 0; i < NR; i++) begin
          idcnt[i] <= idcnt[i] + ((push_ok && bus.fifo_wdata[33:32] == 2'(i)) ? 1 : 0)
                               - ((pop_ok && mem[rp][33:32] == 2'(i)) ? 1 : 0);
        end
      end
    end

    // Occupancy must track the FIFO; no push into a full FIFO; quota never exceeded.
    always @(negedge clk) begin
      if (rst) begin
        checks++;
        if (bus.occ !== cnt) begin
          errors++;
          $display("FAIL occ_track[%0d]: got %0d expected %0d", k, bus.occ, cnt);
        end
        checks++;
        if (bus.fifo_push && cnt == 6'd32) begin
          errors++;
          $display("FAIL push_when_full[%0d]: got push=1 expected push=0", k);
        end
        for (int i = 0; i < NR; i++) begin
          checks++;
          if (idcnt[i] > int'(Q) || idcnt[i] < 0) begin
            errors++;
            $display("FAIL quota_bound[%0d] req %0d: got %0d expected 0..%0d", k, i, idcnt[i], Q);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [31:0] base);
    for (int i = 0; i < NR; i++) req_data[k][i*DB +: DB] = base + 32'(i);
  endtask

  task automatic drain(input int k);
    req_val[k]  = '0;
    resp_rdy[k] = 1'b1;
    for (int n = 0; n < 40 && resp_val[k]; n++) tick();
    checks++;
    if (resp_val[k]) begin
      errors++;
      $display("FAIL drain[%0d]: got resp_val=1 expected 0 within 40 cycles", k);
    end
    resp_rdy[k] = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [3:0]  val;
    logic        rr;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  id;
    logic [31:0] data;
    logic [5:0]  occ;
  } vec_t;

  vec_t tbl [14];

  initial begin
    checks = 0;
    errors = 0;
    // Payload for requester i in row r is (r << 8) | i.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h000, 6'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h000, 6'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h101, 6'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h202, 6'd1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h303, 6'd1};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h400, 6'd1};
    tbl[6]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd1, 32'h501, 6'd1};
    tbl[7]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 2'd3, 32'h603, 6'd1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h603, 6'd2};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 32'h603, 6'd2};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h701, 6'd1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h000, 6'd0};
    tbl[12] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 32'h000, 6'd0};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hC02, 6'd1};

    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_val[k]  = '0;
      resp_rdy[k] = 1'b0;
      set_data(k, 32'h0);
    end
    req_val[0]  = 4'b1111;
    resp_rdy[0] = 1'b1;

    // Reset holds every control output low.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_rdy", 64'(req_rdy[0]), 64'h0);
    chk("rst_push", 64'(fifo_push[0]), 64'h0);
    chk("rst_pop", 64'(fifo_pop[0]), 64'h0);
    chk("rst_resp_val", 64'(resp_val[0]), 64'h0);
    chk("rst_occ", 64'(occ[0]), 64'h0);
    rst = 1'b1;
    #1;

    // Round-robin and mixed request/response patterns.
    for (int r = 0; r < 14; r++) begin
      req_val[0]  = tbl[r].val;
      resp_rdy[0] = tbl[r].rr;
      set_data(0, 32'(r) << 8);
      #1;
      chk($sformatf("vec%0d_req_rdy", r), 64'(req_rdy[0]), 64'(tbl[r].rdy));
      chk($sformatf("vec%0d_push", r), 64'(fifo_push[0]), 64'(|tbl[r].rdy));
      chk($sformatf("vec%0d_pop", r), 64'(fifo_pop[0]), 64'(tbl[r].rv & tbl[r].rr));
      chk($sformatf("vec%0d_resp_val", r), 64'(resp_val[0]), 64'(tbl[r].rv));
      chk($sformatf("vec%0d_occ", r), 64'(occ[0]), 64'(tbl[r].occ));
      if (tbl[r].rv) begin
        chk($sformatf("vec%0d_resp_id", r), 64'(resp_id[0]), 64'(tbl[r].id));
        chk($sformatf("vec%0d_resp_data", r), 64'(resp_data[0]), 64'(tbl[r].data));
      end
      tick();
    end
    drain(0);

    // Quota: requester 2 alone fills its 8 slots, then is held off.
    req_val[0]  = 4'b0100;
    resp_rdy[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("quota_fill%0d_rdy", j), 64'(req_rdy[0]), 64'b0100);
      chk($sformatf("quota_fill%0d_occ", j), 64'(occ[0]), 64'(j));
      tick();
    end
    chk("quota_block_rdy", 64'(req_rdy[0]), 64'b0000);
    chk("quota_block_occ", 64'(occ[0]), 64'd8);
    req_val[0] = 4'b0101;
    #1;
    chk("quota_other_rdy", 64'(req_rdy[0]), 64'b0001);
    req_val[0]  = 4'b0100;
    resp_rdy[0] = 1'b1;
    #1;
    chk("quota_pop", 64'(fifo_pop[0]), 64'h1);
    chk("quota_pop_id", 64'(resp_id[0]), 64'd2);
    chk("quota_pop_rdy", 64'(req_rdy[0]), 64'b0000);
    tick();
    resp_rdy[0] = 1'b0;
    #1;
    chk("quota_regrant_rdy", 64'(req_rdy[0]), 64'b0100);
    chk("quota_regrant_occ", 64'(occ[0]), 64'd7);
    tick();
    chk("quota_refill_occ", 64'(occ[0]), 64'd8);
    drain(0);

    // Streaming push and pop together: occupancy steady, order preserved.
    req_val[0]  = 4'b0010;
    resp_rdy[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      req_data[0][63:32] = 32'hBEEF_0000 + 32'(j);
      #1;
      chk($sformatf("stream%0d_rdy", j), 64'(req_rdy[0]), 64'b0010);
      chk($sformatf("stream%0d_occ", j), 64'(occ[0]), (j == 0) ? 64'd0 : 64'd1);
      if (j > 0) begin
        chk($sformatf("stream%0d_id", j), 64'(resp_id[0]), 64'd1);
        chk($sformatf("stream%0d_data", j), 64'(resp_data[0]), 64'(32'hBEEF_0000 + 32'(j - 1)));
      end
      tick();
    end
    drain(0);

    // Full: quota 32 instance, two requesters fill the whole FIFO.
    req_val[1]  = 4'b0011;
    resp_rdy[1] = 1'b0;
    for (int j = 0; j < 32; j++) begin
      set_data(1, 32'(j) << 8);
      #1;
      chk($sformatf("full_fill%0d_rdy", j), 64'(req_rdy[1]), (j % 2 == 1) ? 64'b0010 : 64'b0001);
      tick();
    end
    chk("full_block_rdy", 64'(req_rdy[1]), 64'b0000);
    chk("full_block_push", 64'(fifo_push[1]), 64'h0);
    chk("full_occ", 64'(occ[1]), 64'd32);
    resp_rdy[1] = 1'b1;
    #1;
    chk("full_poppush_pop", 64'(fifo_pop[1]), 64'h1);
    chk("full_poppush_push", 64'(fifo_push[1]), 64'h0);
    chk("full_poppush_rdy", 64'(req_rdy[1]), 64'b0000);
    tick();
    resp_rdy[1] = 1'b0;
    #1;
    chk("full_resume_rdy", 64'(req_rdy[1]), 64'b0001);
    chk("full_resume_push", 64'(fifo_push[1]), 64'h1);
    chk("full_resume_occ", 64'(occ[1]), 64'd31);
    tick();
    chk("full_refill_occ", 64'(occ[1]), 64'd32);
    req_val[1] = '0;

    // Mid-operation asynchronous reset with five entries queued.
    req_val[0]  = 4'b1111;
    resp_rdy[0] = 1'b0;
    repeat (5) tick();
    chk("midrst_pre_occ", 64'(occ[0]), 64'd5);
    resp_rdy[0] = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_req_rdy", 64'(req_rdy[0]), 64'h0);
    chk("midrst_push", 64'(fifo_push[0]), 64'h0);
    chk("midrst_pop", 64'(fifo_pop[0]), 64'h0);
    chk("midrst_resp_val", 64'(resp_val[0]), 64'h0);
    chk("midrst_occ", 64'(occ[0]), 64'h0);
    if (fempty[0]) $display("note: FIFO already empty at async reset assertion");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("postrst_req_rdy", 64'(req_rdy[0]), 64'b0001);
    chk("postrst_resp_val", 64'(resp_val[0]), 64'h0);
    chk("postrst_occ", 64'(occ[0]), 64'h0);
    tick();
    chk("postrst_first_id", 64'(resp_id[0]), 64'd0);
    chk("postrst_first_occ", 64'(occ[0]), 64'd1);
    req_val[0] = '0;
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
